// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory engine: opcodes, mode byte, FSM states.
// Optional feature macro: SPI_MODE_INIT_EN (adds the INIT state).
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [7:0] CMD_WRMR        = 8'h01;
  localparam logic [7:0] MODE_SEQUENTIAL = 8'h40;

`ifdef SPI_MODE_INIT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    INIT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: frame shift register, bit counter and phase toggle.
// Each bit takes two clk cycles: phase 0 (sclk low, mosi presented) and
// phase 1 (sclk high, miso sampled at the end of the phase).
module spi_shifter #(
  parameter int FRAME_BITS = 40,
  parameter int RX_BITS    = 16,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic [CNT_W-1:0]      i_len,
  input  logic                  i_en,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic [RX_BITS-1:0]    o_rx,
  output logic                  o_last
);

  logic [FRAME_BITS-1:0] r_sr;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_len;
  logic                  r_phase;
  logic                  r_sclk;
  logic                  r_mosi;
  logic [RX_BITS-1:0]    r_rx;

  // Load a new frame, then alternate phases while enabled; the first bit is
  // placed on mosi at load so it is stable for the whole first bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_rx    <= '0;
    end else if (i_load) begin
      r_sr    <= {i_frame[FRAME_BITS-2:0], 1'b0};
      r_mosi  <= i_frame[FRAME_BITS-1];
      r_len   <= i_len;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b0;
    end else if (i_en) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
        r_sclk  <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_sclk  <= 1'b0;
        r_rx    <= {r_rx[RX_BITS-2:0], i_miso};
        r_cnt   <= r_cnt + CNT_W'(1);
        r_mosi  <= r_sr[FRAME_BITS-1];
        r_sr    <= {r_sr[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // Final cycle of the frame: phase 1 of the last bit.
  always_comb begin
    o_last = i_en && r_phase && (r_cnt == r_len - CNT_W'(1));
  end

  assign o_sclk = r_sclk;
  assign o_mosi = r_mosi;
  assign o_rx   = r_rx;

endmodule

// File: rtl/spi_mem_engine.sv
// SPI memory access engine: accepts read/write requests and issues
// {cmd, addr, data} frames through spi_shifter.
// Optional feature macro: SPI_MODE_INIT_EN (send WRMR sequential-mode frame
// after reset before accepting requests).
//
// Handshake: a request is accepted on the rising edge where the engine is in
// IDLE and start_write or start_read is high (write wins); busy rises on the
// next cycle and stays high until the cycle after DONE, when a new request
// may be presented. Starts while busy are ignored, not queued.
module spi_mem_engine
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ADDR_BITS        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_BITS-1:0]          addr_in,
  input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
  input  logic                          start_read,
  input  logic                          start_write,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          busy,
  output logic                          spi_select,
  output logic                          spi_clk_out,
  output logic                          spi_mosi,
  input  logic                          spi_miso,
  output state_t                        o_dbg_state
);

  localparam int DW = 8 * DATA_WIDTH_BYTES;
  localparam int FB = 8 + ADDR_BITS + DW;
  localparam int CW = $clog2(FB + 1);

`ifdef SPI_MODE_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t          r_state;
  state_t          w_next;
  logic            r_busy;
  logic            r_sel;
  logic            r_is_read;
  logic [DW-1:0]   r_data_out;
  logic            w_load;
  logic            w_load_read;
  logic [FB-1:0]   w_frame;
  logic [CW-1:0]   w_len;
  logic            w_last;
  logic [DW-1:0]   w_rx;

  // Next-state decode and frame assembly for the shifter load.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_read = 1'b0;
    w_frame     = '0;
    w_len       = CW'(FB);
    case (r_state)
      IDLE: begin
        if (start_write) begin
          w_next  = SHIFT;
          w_load  = 1'b1;
          w_frame = {CMD_WRITE, addr_in, data_in};
        end else if (start_read) begin
          w_next      = SHIFT;
          w_load      = 1'b1;
          w_load_read = 1'b1;
          w_frame     = {CMD_READ, addr_in, {DW{1'b0}}};
        end
      end
      SHIFT: if (w_last) w_next = DONE;
      DONE:  w_next = IDLE;
`ifdef SPI_MODE_INIT_EN
      INIT: begin
        w_next  = SHIFT;
        w_load  = 1'b1;
        w_frame = {CMD_WRMR, MODE_SEQUENTIAL, {(FB-16){1'b0}}};
        w_len   = CW'(16);
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // State register plus registered busy/select and read-result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RST_STATE;
      r_busy     <= 1'b0;
      r_sel      <= 1'b1;
      r_is_read  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_sel   <= (w_next != SHIFT);
      if (w_load) r_is_read <= w_load_read;
      if (r_state == DONE && r_is_read) r_data_out <= w_rx;
    end
  end

  spi_shifter #(
    .FRAME_BITS (FB),
    .RX_BITS    (DW),
    .CNT_W      (CW)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_frame (w_frame),
    .i_len   (w_len),
    .i_en    (r_state == SHIFT),
    .i_miso  (spi_miso),
    .o_sclk  (spi_clk_out),
    .o_mosi  (spi_mosi),
    .o_rx    (w_rx),
    .o_last  (w_last)
  );

  assign data_out    = r_data_out;
  assign busy        = r_busy;
  assign spi_select  = r_sel;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_mem_engine.sv
// Directed bench for spi_mem_engine at default parameters, with a bus monitor
// that records MOSI bits, select/busy durations and serves MISO from resp_word.
module tb_spi_mem_engine;
  import spi_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_in = '0;
  logic [15:0] data_in = '0;
  logic        start_read = 1'b0;
  logic        start_write = 1'b0;
  logic [15:0] data_out;
  logic        busy;
  logic        spi_select;
  logic        spi_clk_out;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  // monitor state
  logic [63:0] mosi_bits = '0;
  logic [15:0] resp_word = '0;
  logic [39:0] resp_frame;
  int frames = 0, sel_cnt = 0, busy_cnt = 0, bit_cnt = 0, hi_cnt = 0, last_gap = 0;
  logic prev_sel = 1'b1, prev_busy = 1'b0;
  int f0;

  spi_mem_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .start_read  (start_read),
    .start_write (start_write),
    .data_out    (data_out),
    .busy        (busy),
    .spi_select  (spi_select),
    .spi_clk_out (spi_clk_out),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bus monitor and MISO model (memory answers resp_word after cmd+addr)
  always @(negedge clk) begin
    resp_frame = {24'h0, resp_word};
    if (!spi_select) begin
      if (prev_sel) begin
        frames++;
        last_gap = hi_cnt;
        sel_cnt  = 0;
        bit_cnt  = 0;
      end
      sel_cnt++;
      if (spi_clk_out) begin
        mosi_bits = {mosi_bits[62:0], spi_mosi};
        bit_cnt++;
      end else begin
        spi_miso = (bit_cnt < 40) ? resp_frame[39 - bit_cnt] : 1'b0;
      end
      hi_cnt = 0;
    end else begin
      hi_cnt++;
    end
    if (busy) begin
      if (!prev_busy) busy_cnt = 0;
      busy_cnt++;
    end
    prev_sel  = spi_select;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge; holds the start for one accepting edge
  task automatic do_start(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input bit expect_accept, input string tag);
    addr_in     = a;
    data_in     = d;
    start_read  = rd;
    start_write = wr;
    @(negedge clk);
    start_read  = 1'b0;
    start_write = 1'b0;
    addr_in     = 16'($urandom_range(0, 65535));
    data_in     = 16'($urandom_range(0, 65535));
    if (expect_accept) begin
      chk({tag, "_busy_next"}, 64'(busy), 64'(1));
      chk({tag, "_sel_next"}, 64'(spi_select), 64'(0));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk({tag, "_timeout"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sel", 64'(spi_select), 64'(1));
    chk("rst_sclk", 64'(spi_clk_out), 64'(0));
    chk("rst_mosi", 64'(spi_mosi), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

`ifdef SPI_MODE_INIT_EN
    f0 = frames;
    @(negedge clk);
    chk("init_busy", 64'(busy), 64'(1));
    do_start(1'b1, 1'b0, 16'h5555, 16'h0, 1'b0, "init_start");
    wait_idle("init");
    chk("init_mosi", 64'(mosi_bits[15:0]), 64'(16'h0140));
    chk("init_busy_len", 64'(busy_cnt), 64'(33));
    chk("init_data", 64'(data_out), 64'(0));
    repeat (3) @(negedge clk);
    chk("init_ignored", 64'(frames - f0), 64'(1));
`else
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_state", 64'(dbg_state), 64'(IDLE));
`endif

    // basic read
    resp_word = 16'hBEEF;
    do_start(1'b1, 1'b0, 16'h1234, 16'h0, 1'b1, "rd1");
    wait_idle("rd1");
    chk("rd1_mosi", 64'(mosi_bits[39:0]), 64'(40'h0312340000));
    chk("rd1_sel_len", 64'(sel_cnt), 64'(80));
    chk("rd1_busy_len", 64'(busy_cnt), 64'(81));
    chk("rd1_data", 64'(data_out), 64'(16'hBEEF));
    chk("rd1_state", 64'(dbg_state), 64'(IDLE));

    // basic write
    resp_word = 16'h0F0F;
    do_start(1'b0, 1'b1, 16'h00FF, 16'hA55A, 1'b1, "wr1");
    wait_idle("wr1");
    chk("wr1_mosi", 64'(mosi_bits[39:0]), 64'(40'h0200FFA55A));
    chk("wr1_data", 64'(data_out), 64'(16'hBEEF));

    // simultaneous starts: write wins, read dropped
    f0 = frames;
    do_start(1'b1, 1'b1, 16'h1111, 16'h3C3C, 1'b1, "both");
    wait_idle("both");
    repeat (4) @(negedge clk);
    chk("both_mosi", 64'(mosi_bits[39:0]), 64'(40'h0211113C3C));
    chk("both_frames", 64'(frames - f0), 64'(1));
    chk("both_data", 64'(data_out), 64'(16'hBEEF));

    // start pulse at cycle 40 of an active read is ignored
    f0 = frames;
    resp_word = 16'h5AA5;
    do_start(1'b1, 1'b0, 16'hCAFE, 16'h0, 1'b1, "rd2");
    repeat (38) @(negedge clk);
    addr_in    = 16'hDEAD;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
    wait_idle("rd2");
    repeat (4) @(negedge clk);
    chk("rd2_frames", 64'(frames - f0), 64'(1));
    chk("rd2_mosi", 64'(mosi_bits[39:0]), 64'(40'h03CAFE0000));
    chk("rd2_data", 64'(data_out), 64'(16'h5AA5));

    // back-to-back: new start in first busy=0 cycle
    f0 = frames;
    resp_word = 16'h1234;
    do_start(1'b1, 1'b0, 16'h0F0F, 16'h0, 1'b1, "b2b_a");
    wait_idle("b2b_a");
    chk("b2b_a_data", 64'(data_out), 64'(16'h1234));
    resp_word = 16'hC3C3;
    do_start(1'b1, 1'b0, 16'h00F0, 16'h0, 1'b1, "b2b_b");
    wait_idle("b2b_b");
    chk("b2b_frames", 64'(frames - f0), 64'(2));
    chk("b2b_gap", 64'(last_gap), 64'(2));
    chk("b2b_mosi", 64'(mosi_bits[39:0]), 64'(40'h0300F00000));
    chk("b2b_data", 64'(data_out), 64'(16'hC3C3));

    // reset in the middle of a read
    resp_word = 16'hFFFF;
    do_start(1'b1, 1'b0, 16'h4321, 16'h0, 1'b1, "abort");
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sel", 64'(spi_select), 64'(1));
    chk("abort_data", 64'(data_out), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_sclk", 64'(spi_clk_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SPI_MODE_INIT_EN
    @(negedge clk);
    wait_idle("abort_init");
`endif
    resp_word = 16'h8001;
    do_start(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, "rd3");
    wait_idle("rd3");
    chk("rd3_mosi", 64'(mosi_bits[39:0]), 64'(40'h0300010000));
    chk("rd3_sel_len", 64'(sel_cnt), 64'(80));
    chk("rd3_data", 64'(data_out), 64'(16'h8001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
